// File: rtl/wb_pkg.sv
// Shared encodings and types for the write-back stage: result select,
// load funct3 codes, entry state and captured control fields.
package wb_pkg;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_CSR = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [2:0] funct3;
    logic [2:0] addr_lo;
  } wb_ctrl_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB handshake, data-memory return and register-file write port bundle.
interface wb_stage_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_alu_result;
  logic [XLEN-1:0]   in_pc_plus4;
  logic [XLEN-1:0]   in_csr_rdata;
  logic [REG_AW-1:0] in_rd;
  logic              in_reg_write;
  logic [1:0]        in_wb_sel;
  logic [2:0]        in_funct3;
  logic [2:0]        in_addr_lo;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;
  logic [XLEN-1:0]   wb_data;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrite;
  logic              load_err;
  logic [CNT_W-1:0]  retire_count;

  modport slave (
    input  in_valid, in_alu_result, in_pc_plus4, in_csr_rdata, in_rd,
           in_reg_write, in_wb_sel, in_funct3, in_addr_lo,
           mem_rvalid, mem_rdata,
    output in_ready, wb_data, wb_rd, wb_regwrite, load_err, retire_count
  );

  modport master (
    output in_valid, in_alu_result, in_pc_plus4, in_csr_rdata, in_rd,
           in_reg_write, in_wb_sel, in_funct3, in_addr_lo,
           mem_rvalid, mem_rdata,
    input  in_ready, wb_data, wb_rd, wb_regwrite, load_err, retire_count
  );
endinterface

// File: rtl/wb_stage_load_extend.sv
// Combinational load alignment: picks the addressed element of the returned
// word and sign/zero-extends it; flags encodings unsupported at this XLEN.
module load_extend
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [2:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_data,
  output logic            o_supported
);

  localparam bit IS64 = (XLEN == 64);

  logic [2:0]      w_mask;
  logic [XLEN-1:0] w_shift;
  logic [XLEN-1:0] w_ext;
  logic            w_ok;

  always_comb begin
    w_mask = '0;
    w_ok   = 1'b1;
    // Mask keeps only the offset bits that select an element of this size.
    case (i_funct3)
      F3_LB, F3_LBU: w_mask = IS64 ? 3'd7 : 3'd3;
      F3_LH, F3_LHU: w_mask = IS64 ? 3'd6 : 3'd2;
      F3_LW:         w_mask = IS64 ? 3'd4 : 3'd0;
      F3_LWU: begin
        w_mask = 3'd4;
        w_ok   = IS64;
      end
      F3_LD:         w_ok   = IS64;
      default:       w_ok   = 1'b0;
    endcase

    w_shift = i_rdata >> {(i_addr_lo & w_mask), 3'b000};

    case (i_funct3)
      F3_LB:   w_ext = XLEN'($signed(w_shift[7:0]));
      F3_LH:   w_ext = XLEN'($signed(w_shift[15:0]));
      F3_LW:   w_ext = XLEN'($signed(w_shift[31:0]));
      F3_LBU:  w_ext = XLEN'(w_shift[7:0]);
      F3_LHU:  w_ext = XLEN'(w_shift[15:0]);
      F3_LWU:  w_ext = XLEN'(w_shift[31:0]);
      F3_LD:   w_ext = w_shift;
      default: w_ext = '0;
    endcase

    o_data      = w_ok ? w_ext : '0;
    o_supported = w_ok;
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: one-entry MEM/WB holding register, result select, load
// wait with bounded timeout, register-file write port and retire counter.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned CNT_W   = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave bus
);

  localparam int unsigned     WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] TMO = WCW'(TIMEOUT);

  wb_state_e         r_state;
  wb_ctrl_t          r_ctrl;
  logic [XLEN-1:0]   r_res;
  logic [REG_AW-1:0] r_rd;
  logic [WCW-1:0]    r_wait;
  logic [CNT_W-1:0]  r_cnt;

  logic            w_full;
  logic            w_is_load;
  logic            w_wait_max;
  logic            w_timeout;
  logic            w_retire;
  logic            w_ready;
  logic            w_accept;
  logic            w_ld_ok;
  logic [XLEN-1:0] w_ld_data;
  logic [XLEN-1:0] w_sel_res;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .i_funct3    (r_ctrl.funct3),
    .i_addr_lo   (r_ctrl.addr_lo),
    .i_rdata     (bus.mem_rdata),
    .o_data      (w_ld_data),
    .o_supported (w_ld_ok)
  );

  always_comb begin
    w_full     = (r_state == ST_FULL);
    w_is_load  = (r_ctrl.wb_sel == WB_MEM);
    w_wait_max = (r_wait == TMO);
    // Data arriving in the last allowed cycle still counts as a good load.
    w_timeout  = w_full && w_is_load && !bus.mem_rvalid && w_wait_max;
    w_retire   = w_full && (!w_is_load || bus.mem_rvalid || w_wait_max);
    w_ready    = !w_full || w_retire;
    w_accept   = bus.in_valid && w_ready;
  end

  // Non-load results are chosen at capture; only load data stays live.
  always_comb begin
    case (bus.in_wb_sel)
      WB_PC4:  w_sel_res = bus.in_pc_plus4;
      WB_CSR:  w_sel_res = bus.in_csr_rdata;
      default: w_sel_res = bus.in_alu_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_ctrl  <= '0;
      r_res   <= '0;
      r_rd    <= '0;
      r_wait  <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_retire) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_accept) begin
        r_state        <= ST_FULL;
        r_ctrl.reg_write <= bus.in_reg_write;
        r_ctrl.wb_sel  <= bus.in_wb_sel;
        r_ctrl.funct3  <= bus.in_funct3;
        r_ctrl.addr_lo <= bus.in_addr_lo;
        r_res          <= w_sel_res;
        r_rd           <= bus.in_rd;
        r_wait         <= '0;
      end else if (w_retire) begin
        r_state <= ST_EMPTY;
      end else if (w_full && !w_wait_max) begin
        r_wait <= r_wait + WCW'(1);
      end
    end
  end

  always_comb begin
    bus.in_ready     = w_ready;
    bus.wb_data      = w_is_load ? w_ld_data : r_res;
    bus.wb_rd        = r_rd;
    bus.wb_regwrite  = w_retire && r_ctrl.reg_write && (r_rd != '0) &&
                       !w_timeout && (!w_is_load || w_ld_ok);
    bus.load_err     = w_timeout;
    bus.retire_count = r_cnt;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: a 32-bit (TIMEOUT=5) and a 64-bit (TIMEOUT=3) instance
// share one stimulus stream and are checked against a transaction-level model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_rw, s_rvalid;
  logic [1:0]  s_sel;
  logic [4:0]  s_rd;
  logic [2:0]  s_f3, s_lo;
  logic [63:0] s_alu, s_pc4, s_csr, s_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_stage_if #(.XLEN(32), .REG_AW(5), .CNT_W(64)) bus32 ();
  wb_stage_if #(.XLEN(64), .REG_AW(5), .CNT_W(64)) bus64 ();

  wb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(64), .TIMEOUT(5)) u_dut32 (
    .clk (clk), .rst (rst), .bus (bus32)
  );
  wb_stage #(.XLEN(64), .REG_AW(5), .CNT_W(64), .TIMEOUT(3)) u_dut64 (
    .clk (clk), .rst (rst), .bus (bus64)
  );

  assign bus32.in_valid      = s_valid;
  assign bus32.in_alu_result = s_alu[31:0];
  assign bus32.in_pc_plus4   = s_pc4[31:0];
  assign bus32.in_csr_rdata  = s_csr[31:0];
  assign bus32.in_rd         = s_rd;
  assign bus32.in_reg_write  = s_rw;
  assign bus32.in_wb_sel     = s_sel;
  assign bus32.in_funct3     = s_f3;
  assign bus32.in_addr_lo    = s_lo;
  assign bus32.mem_rvalid    = s_rvalid;
  assign bus32.mem_rdata     = s_rdata[31:0];

  assign bus64.in_valid      = s_valid;
  assign bus64.in_alu_result = s_alu;
  assign bus64.in_pc_plus4   = s_pc4;
  assign bus64.in_csr_rdata  = s_csr;
  assign bus64.in_rd         = s_rd;
  assign bus64.in_reg_write  = s_rw;
  assign bus64.in_wb_sel     = s_sel;
  assign bus64.in_funct3     = s_f3;
  assign bus64.in_addr_lo    = s_lo;
  assign bus64.mem_rvalid    = s_rvalid;
  assign bus64.mem_rdata     = s_rdata;

  logic        obs_rdy [2];
  logic        obs_we  [2];
  logic        obs_err [2];
  logic [4:0]  obs_rd  [2];
  logic [63:0] obs_data[2];
  logic [63:0] obs_cnt [2];

  assign obs_rdy[0]  = bus32.in_ready;
  assign obs_we[0]   = bus32.wb_regwrite;
  assign obs_err[0]  = bus32.load_err;
  assign obs_rd[0]   = bus32.wb_rd;
  assign obs_data[0] = {32'h0, bus32.wb_data};
  assign obs_cnt[0]  = bus32.retire_count;
  assign obs_rdy[1]  = bus64.in_ready;
  assign obs_we[1]   = bus64.wb_regwrite;
  assign obs_err[1]  = bus64.load_err;
  assign obs_rd[1]   = bus64.wb_rd;
  assign obs_data[1] = bus64.wb_data;
  assign obs_cnt[1]  = bus64.retire_count;

  // Reference model: one pending instruction per configuration.
  bit          m_full[2];
  int          m_wait[2];
  logic [63:0] m_cnt [2];
  logic [1:0]  m_sel [2];
  bit          m_rw  [2];
  logic [4:0]  m_rd  [2];
  logic [2:0]  m_f3  [2], m_lo[2];
  logic [63:0] m_alu [2], m_pc4[2], m_csr[2];
  bit          e_ret [2], e_rdy[2];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ld_val(int xl, logic [2:0] f3, logic [2:0] lo,
                                         logic [63:0] raw, output bit ok);
    int sz;
    int off;
    bit sgn;
    logic [63:0] v;
    ok  = 1'b1;
    sgn = !f3[2];
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2, 3'd6: sz = 4;
      3'd3:       sz = 8;
      default: begin sz = 1; ok = 1'b0; end
    endcase
    if (xl == 32 && (f3 == 3'd3 || f3 == 3'd6)) ok = 1'b0;
    if (xl == 32) raw[63:32] = '0;
    off = ((int'(lo) % (xl / 8)) / sz) * sz;
    v = '0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = raw[8*(off+i) +: 8];
    if (sgn && v[8*sz-1]) for (int b = 8*sz; b < 64; b++) v[b] = 1'b1;
    if (xl == 32) v[63:32] = '0;
    if (!ok) v = '0;
    return v;
  endfunction

  task automatic m_reset(int k);
    m_full[k] = 0; m_wait[k] = 0; m_cnt[k] = '0; m_sel[k] = '0; m_rw[k] = 0;
    m_rd[k] = '0; m_f3[k] = '0; m_lo[k] = '0;
    m_alu[k] = '0; m_pc4[k] = '0; m_csr[k] = '0;
  endtask

  task automatic eval();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int          xl;
      int          tm;
      bit          ok;
      bit          tmo;
      logic [63:0] ldv;
      logic [63:0] d;
      xl  = (k == 0) ? 32 : 64;
      tm  = (k == 0) ? 5 : 3;
      ldv = ld_val(xl, m_f3[k], m_lo[k], s_rdata, ok);
      e_ret[k] = m_full[k] && (m_sel[k] != 2'd1 || s_rvalid || m_wait[k] == tm);
      e_rdy[k] = !m_full[k] || e_ret[k];
      tmo = m_full[k] && m_sel[k] == 2'd1 && !s_rvalid && m_wait[k] == tm;
      case (m_sel[k])
        2'd0:    d = m_alu[k];
        2'd1:    d = ldv;
        2'd2:    d = m_pc4[k];
        default: d = m_csr[k];
      endcase
      chk($sformatf("in_ready[%0d]", k), 64'(obs_rdy[k]), 64'(e_rdy[k]));
      chk($sformatf("wb_regwrite[%0d]", k), 64'(obs_we[k]),
          64'(e_ret[k] && m_rw[k] && m_rd[k] != 0 && !tmo && (m_sel[k] != 2'd1 || ok)));
      chk($sformatf("load_err[%0d]", k), 64'(obs_err[k]), 64'(tmo));
      chk($sformatf("wb_rd[%0d]", k), 64'(obs_rd[k]), 64'(m_rd[k]));
      chk($sformatf("retire_count[%0d]", k), obs_cnt[k], m_cnt[k]);
      if (m_full[k]) chk($sformatf("wb_data[%0d]", k), obs_data[k], d);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      int          tm;
      logic [63:0] msk;
      tm  = (k == 0) ? 5 : 3;
      msk = (k == 0) ? 64'h0000_0000_FFFF_FFFF : '1;
      if (rst) m_reset(k);
      else begin
        if (e_ret[k]) m_cnt[k] = m_cnt[k] + 64'd1;
        if (s_valid && e_rdy[k]) begin
          m_full[k] = 1; m_wait[k] = 0; m_sel[k] = s_sel; m_rw[k] = s_rw;
          m_rd[k] = s_rd; m_f3[k] = s_f3; m_lo[k] = s_lo;
          m_alu[k] = s_alu & msk; m_pc4[k] = s_pc4 & msk; m_csr[k] = s_csr & msk;
        end else if (e_ret[k]) m_full[k] = 0;
        else if (m_full[k] && m_wait[k] < tm) m_wait[k]++;
      end
    end
    #1;
  endtask

  task automatic idle();
    s_valid = 0; s_rw = 0; s_rvalid = 0; s_sel = '0; s_rd = '0; s_f3 = '0;
    s_lo = '0; s_alu = '0; s_pc4 = '0; s_csr = '0; s_rdata = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    m_reset(0);
    m_reset(1);
    @(posedge clk);
    #1;
    eval(); adv();
    eval();
    chk("reset_ready", 64'(obs_rdy[0]), 64'd1);
    chk("reset_data", obs_data[1], 64'd0);
    adv();
    rst = 1'b0;

    // ALU back-to-back, rd 5/6/7
    s_rw = 1;
    for (int i = 0; i < 4; i++) begin
      s_valid = (i < 3);
      s_rd    = 5'(5 + i);
      s_alu   = 64'(17 * (i + 1));
      eval();
      if (i > 0) begin
        chk("b2b_we", 64'(obs_we[0]), 64'd1);
        chk("b2b_data", obs_data[0], 64'(17 * i));
        chk("b2b_rd", 64'(obs_rd[0]), 64'(4 + i));
      end
      adv();
    end
    idle();
    eval();
    chk("b2b_count", obs_cnt[0], 64'd3);
    adv();

    // LB then LBU on byte 3 of 0x80FF_0000
    for (int j = 0; j < 2; j++) begin
      idle();
      s_valid = 1; s_sel = 2'd1; s_rw = 1; s_rd = 5'd8; s_lo = 3'd3;
      s_f3 = (j == 0) ? 3'b000 : 3'b100;
      s_rdata = 64'h0000_0000_80FF_0000;
      eval(); adv();
      s_valid = 0; s_rvalid = 1;
      eval();
      chk("lb_we", 64'(obs_we[0]), 64'd1);
      chk("lb_data32", obs_data[0], (j == 0) ? 64'h0000_0000_FFFF_FF80 : 64'h80);
      chk("lb_data64", obs_data[1], (j == 0) ? 64'hFFFF_FFFF_FFFF_FF80 : 64'h80);
      adv();
    end

    // Load wait of 4 cycles (32-bit instance stays within TIMEOUT=5)
    idle();
    s_valid = 1; s_sel = 2'd1; s_rw = 1; s_rd = 5'd9; s_f3 = 3'b010;
    eval(); adv();
    s_valid = 0;
    for (int i = 0; i < 4; i++) begin
      eval();
      chk("wait_ready", 64'(obs_rdy[0]), 64'd0);
      chk("wait_we", 64'(obs_we[0]), 64'd0);
      adv();
    end
    s_rvalid = 1; s_rdata = 64'h1234_5678_CAFE_F00D;
    eval();
    chk("wait_we_rvalid", 64'(obs_we[0]), 64'd1);
    chk("wait_ready_rvalid", 64'(obs_rdy[0]), 64'd1);
    chk("wait_data", obs_data[0], 64'h0000_0000_CAFE_F00D);
    adv();

    // Timeout with no rvalid: 64-bit at its 4th FULL cycle, 32-bit at 6th
    idle();
    s_valid = 1; s_sel = 2'd1; s_rw = 1; s_rd = 5'd10; s_f3 = 3'b000;
    eval(); adv();
    s_valid = 0;
    for (int i = 0; i < 6; i++) begin
      eval();
      chk("tmo_err64", 64'(obs_err[1]), 64'(i == 3));
      chk("tmo_err32", 64'(obs_err[0]), 64'(i == 5));
      chk("tmo_we64", 64'(obs_we[1]), 64'd0);
      adv();
    end

    // x0 destination
    idle();
    s_valid = 1; s_rw = 1; s_rd = 5'd0; s_alu = 64'hDEAD;
    eval(); adv();
    idle();
    eval();
    chk("x0_we", 64'(obs_we[0]), 64'd0);
    adv();

    // Reset during a load wait, then stray rvalid
    s_valid = 1; s_sel = 2'd1; s_rw = 1; s_rd = 5'd3; s_f3 = 3'b010;
    eval(); adv();
    idle();
    eval(); adv();
    rst = 1'b1;
    eval(); adv();
    rst = 1'b0;
    s_rvalid = 1; s_rdata = 64'h5555_5555;
    eval();
    chk("rstload_we", 64'(obs_we[0]), 64'd0);
    chk("rstload_cnt", obs_cnt[0], 64'd0);
    chk("rstload_ready", 64'(obs_rdy[0]), 64'd1);
    chk("rstload_err", 64'(obs_err[0]), 64'd0);
    adv();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      s_valid  = ($urandom_range(0, 3) != 0);
      s_sel    = 2'($urandom_range(0, 3));
      s_rw     = ($urandom_range(0, 7) != 0);
      s_rd     = 5'($urandom);
      s_f3     = 3'($urandom);
      s_lo     = 3'($urandom);
      s_alu    = {$urandom, $urandom};
      s_pc4    = {$urandom, $urandom};
      s_csr    = {$urandom, $urandom};
      s_rvalid = ($urandom_range(0, 99) < 35);
      s_rdata  = {$urandom, $urandom};
      eval(); adv();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
